// File: rtl/ah_dispatch_pkg.sv
// Shared types and default widths for the packet-steering stage that sits
// behind the 34-bit / 10-client range decoder.
package ah_dispatch_pkg;

    localparam int DISP_ADDR_W    = 34;
    localparam int DISP_DATA_W    = 32;
    localparam int DISP_N_CLIENTS = 10;
    localparam int DISP_ERR_CNT_W = 16;

    // Holding-register occupancy: the whole stage is a one-deep skid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

    // Ingress packet as seen by the decoder and the stage.
    typedef struct packed {
        logic [DISP_ADDR_W-1:0] addr;
        logic [DISP_DATA_W-1:0] data;
    } pkt_t;

    // One-hot client select from the decoder.
    typedef logic [DISP_N_CLIENTS-1:0] client_sel_t;

endpackage

// File: rtl/ah_lowest_onehot.sv
// Combinational priority select: keeps only the lowest set bit of i_req and
// flags when more than one bit was set (overlapping decoder ranges).
module ah_lowest_onehot #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_onehot,
    output logic         o_multi
);

    // Scan upward from bit 0; the first set bit wins.
    always_comb begin
        logic w_found;
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        o_onehot = '0;
        w_found  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_req[i] && !w_found) begin
                o_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    // Anything set besides the winner means the select was multi-hot.
    assign o_multi = |(i_req & ~o_onehot);

endmodule

// File: rtl/ah_pkt_dispatch_34_10.sv
// Registered packet-steering stage: takes one packet per cycle on a
// valid/ready handshake, forwards it a cycle later to exactly one client,
// and drops undecodable packets with an error pulse and saturating count.
module ah_pkt_dispatch_34_10
    import ah_dispatch_pkg::*;
#(
    parameter int ADDR_W    = DISP_ADDR_W,
    parameter int DATA_W    = DISP_DATA_W,
    parameter int N_CLIENTS = DISP_N_CLIENTS,
    parameter int ERR_CNT_W = DISP_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    ingress_pkt_field,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [N_CLIENTS-1:0] decoded_binary,
    input  logic                 dec_err,
    output logic [N_CLIENTS-1:0] out_valid,
    input  logic [N_CLIENTS-1:0] out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [DATA_W-1:0]    out_data,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 multi_hit
);

    hold_state_t          r_state;
    hold_state_t          w_state_nxt;
    logic [ADDR_W-1:0]    r_hold_addr;
    logic [DATA_W-1:0]    r_hold_data;
    logic [N_CLIENTS-1:0] r_hold_sel;
    logic                 r_err_valid;
    logic [ADDR_W-1:0]    r_err_addr;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_multi_hit;

    logic                 w_hold_v;
    logic                 w_leave;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_multi;
    logic [N_CLIENTS-1:0] w_sel_lo;

    // Overlapping ranges resolve to the lowest-index client.
    ah_lowest_onehot #(
        .W (N_CLIENTS)
    ) u_lowest_onehot (
        .i_req    (decoded_binary),
        .o_onehot (w_sel_lo),
        .o_multi  (w_multi)
    );

    // A decoder miss, or an empty select, means nobody owns the address.
    assign w_drop   = dec_err | ~(|decoded_binary);
    assign w_accept = in_valid & in_ready;
    assign w_good   = w_accept & ~w_drop;
    assign w_bad    = w_accept & w_drop;

    // State register: the holding slot is either empty or full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Next state: a good accept always (re)fills the slot; otherwise a leave empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_good) begin
            w_state_nxt = ST_FULL;
        end else if (w_leave) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Outputs: egress valid is gated by occupancy; in_ready looks through to out_ready
    // on purpose so a draining slot can refill in the same cycle.
    always_comb begin
        w_hold_v  = (r_state == ST_FULL);
        out_valid = {N_CLIENTS{w_hold_v}} & r_hold_sel;
        w_leave   = w_hold_v & (|(r_hold_sel & out_ready));
        in_ready  = ~w_hold_v | w_leave;
    end

    assign out_addr  = r_hold_addr;
    assign out_data  = r_hold_data;
    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
    assign err_cnt   = r_err_cnt;
    assign multi_hit = r_multi_hit;

    // Holding register: loaded only by a good accept, otherwise kept stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload register is reset too, because the egress buses must read zero out of reset.
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_hold_sel  <= '0;
        end else if (w_good) begin
            r_hold_addr <= ingress_pkt_field;
            r_hold_data <= in_data;
            r_hold_sel  <= w_sel_lo;
        end
    end

    // Drop reporting and the sticky multi-hot flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
            r_multi_hit <= 1'b0;
        end else begin
            r_err_valid <= w_bad;
            if (w_bad) begin
                r_err_addr <= ingress_pkt_field;
                if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
            if (w_good && w_multi) begin
                r_multi_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ah_pkt_dispatch_34_10.sv
// Directed bench for the packet-steering stage: a vector table for the
// single-cycle behaviour plus hand sequences for saturation, multi-hot
// stickiness and asynchronous reset during a stall.
module tb_ah_pkt_dispatch_34_10;
    import ah_dispatch_pkg::*;

    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [33:0]       ingress_pkt_field;
    logic [31:0]       in_data;
    client_sel_t       decoded_binary;
    logic              dec_err;
    client_sel_t       out_valid;
    client_sel_t       out_ready;
    logic [33:0]       out_addr;
    logic [31:0]       out_data;
    logic              err_valid;
    logic [33:0]       err_addr;
    logic [CW-1:0]     err_cnt;
    logic              multi_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        iv;
        logic [33:0] addr;
        logic [31:0] data;
        logic [9:0]  dec;
        logic        derr;
        logic [9:0]  ordy;
        logic        x_ir;
        logic [9:0]  x_ov;
        logic [33:0] x_addr;
        logic [31:0] x_data;
        logic        x_ev;
        logic [33:0] x_eaddr;
        logic [3:0]  x_cnt;
        logic        x_mh;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    ah_pkt_dispatch_34_10 #(
        .ERR_CNT_W (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .ingress_pkt_field (ingress_pkt_field),
        .in_data           (in_data),
        .decoded_binary    (decoded_binary),
        .dec_err           (dec_err),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_addr          (out_addr),
        .out_data          (out_data),
        .err_valid         (err_valid),
        .err_addr          (err_addr),
        .err_cnt           (err_cnt),
        .multi_hit         (multi_hit)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [33:0] a, input logic [31:0] d,
                         input logic [9:0] dec, input logic de, input logic [9:0] ordy);
        in_valid          = iv;
        ingress_pkt_field = a;
        in_data           = d;
        decoded_binary    = dec;
        dec_err           = de;
        out_ready         = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t        pk;
        client_sel_t sel;

        // Single packet, idle, stall of client 2 then drain, errors, error behind a stall, multi-hot.
        tbl[0]  = '{1'b1, 34'h1000, 32'hDEADBEEF, 10'h001, 1'b0, 10'h3FF,
                    1'b1, 10'h001, 34'h1000, 32'hDEADBEEF, 1'b0, 34'h0, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b0, 34'h0, 4'd0, 1'b0};
        tbl[2]  = '{1'b1, 34'h2000, 32'h11111111, 10'h004, 1'b0, 10'h3FB,
                    1'b1, 10'h004, 34'h2000, 32'h11111111, 1'b0, 34'h0, 4'd0, 1'b0};
        for (int i = 3; i <= 6; i++) begin
            tbl[i] = '{1'b1, 34'h2004, 32'h22222222, 10'h004, 1'b0, 10'h3FB,
                       1'b0, 10'h004, 34'h2000, 32'h11111111, 1'b0, 34'h0, 4'd0, 1'b0};
        end
        tbl[7]  = '{1'b1, 34'h2004, 32'h22222222, 10'h004, 1'b0, 10'h3FF,
                    1'b1, 10'h004, 34'h2004, 32'h22222222, 1'b0, 34'h0, 4'd0, 1'b0};
        tbl[8]  = '{1'b1, 34'h2008, 32'h33333333, 10'h004, 1'b0, 10'h3FF,
                    1'b1, 10'h004, 34'h2008, 32'h33333333, 1'b0, 34'h0, 4'd0, 1'b0};
        tbl[9]  = '{1'b0, 34'hABC, 32'hCAFE, 10'h004, 1'b0, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b0, 34'h0, 4'd0, 1'b0};
        tbl[10] = '{1'b1, 34'h3FFFFFFFF, 32'hBAD, 10'h000, 1'b1, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b1, 34'h3FFFFFFFF, 4'd1, 1'b0};
        tbl[11] = '{1'b0, 34'h0, 32'h0, 10'h000, 1'b1, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b0, 34'h3FFFFFFFF, 4'd1, 1'b0};
        tbl[12] = '{1'b1, 34'h1234, 32'h0, 10'h000, 1'b0, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b1, 34'h1234, 4'd2, 1'b0};
        tbl[13] = '{1'b1, 34'h5000, 32'h55555555, 10'h020, 1'b0, 10'h3FF,
                    1'b1, 10'h020, 34'h5000, 32'h55555555, 1'b0, 34'h1234, 4'd2, 1'b0};
        tbl[14] = '{1'b1, 34'h200000000, 32'h0, 10'h000, 1'b1, 10'h3DF,
                    1'b0, 10'h020, 34'h5000, 32'h55555555, 1'b0, 34'h1234, 4'd2, 1'b0};
        tbl[15] = '{1'b1, 34'h200000000, 32'h0, 10'h000, 1'b1, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b1, 34'h200000000, 4'd3, 1'b0};
        tbl[16] = '{1'b1, 34'h6000, 32'h66666666, 10'h00A, 1'b0, 10'h3FF,
                    1'b1, 10'h002, 34'h6000, 32'h66666666, 1'b0, 34'h200000000, 4'd3, 1'b1};
        tbl[17] = '{1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF,
                    1'b1, 10'h000, 34'h0, 32'h0, 1'b0, 34'h200000000, 4'd3, 1'b1};

        // Reset release.
        rst_n = 1'b0;
        drive(1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF);
        #22;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err_cnt",   64'(err_cnt),   64'd0);
        check("rst_multi_hit", 64'(multi_hit), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_out_addr",  64'(out_addr),  64'd0);

        // Table: in_ready checked before the edge, registered outputs after it.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].addr, tbl[i].data, tbl[i].dec, tbl[i].derr, tbl[i].ordy);
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].x_ir));
            tick();
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].x_ov));
            if (tbl[i].x_ov != 10'h000) begin
                check($sformatf("v%0d_out_addr", i), 64'(out_addr), 64'(tbl[i].x_addr));
                check($sformatf("v%0d_out_data", i), 64'(out_data), 64'(tbl[i].x_data));
            end
            check($sformatf("v%0d_err_valid", i), 64'(err_valid), 64'(tbl[i].x_ev));
            check($sformatf("v%0d_err_addr", i),  64'(err_addr),  64'(tbl[i].x_eaddr));
            check($sformatf("v%0d_err_cnt", i),   64'(err_cnt),   64'(tbl[i].x_cnt));
            check($sformatf("v%0d_multi_hit", i), 64'(multi_hit), 64'(tbl[i].x_mh));
        end

        // Ten clean back-to-back packets: multi_hit must stay set.
        for (int i = 0; i < 10; i++) begin
            sel     = client_sel_t'(1) << i;
            pk.addr = 34'h7000 + 34'(i);
            pk.data = 32'hA0A00000 + 32'(i);
            drive(1'b1, pk.addr, pk.data, sel, 1'b0, 10'h3FF);
            #1;
            check($sformatf("clean%0d_in_ready", i), 64'(in_ready), 64'd1);
            tick();
            check($sformatf("clean%0d_out_valid", i), 64'(out_valid), 64'(sel));
            check($sformatf("clean%0d_out_data", i),  64'(out_data),  64'(pk.data));
        end
        drive(1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF);
        tick();
        check("clean_multi_hit_sticky", 64'(multi_hit), 64'd1);
        check("clean_drained",          64'(out_valid), 64'd0);

        // Seventeen back-to-back drops on a 4-bit counter already at 3.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 34'h100 + 34'(i), 32'h0, 10'h000, 1'b1, 10'h3FF);
            tick();
            if (i == 11) check("sat_reach_15", 64'(err_cnt), 64'd15);
        end
        check("sat_hold_15",   64'(err_cnt),   64'd15);
        check("sat_err_addr",  64'(err_addr),  64'h110);
        check("sat_err_valid", 64'(err_valid), 64'd1);
        check("sat_no_egress", 64'(out_valid), 64'd0);
        drive(1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF);
        tick();
        check("sat_pulse_end", 64'(err_valid), 64'd0);
        check("sat_still_15",  64'(err_cnt),   64'd15);

        // Reset asserted while a packet for client 7 is stalled.
        drive(1'b1, 34'h9000, 32'h99999999, 10'h080, 1'b0, 10'h37F);
        tick();
        check("stall7_out_valid", 64'(out_valid), 64'h080);
        drive(1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h37F);
        #1;
        check("stall7_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready",  64'(in_ready),  64'd1);
        check("async_rst_err_cnt",   64'(err_cnt),   64'd0);
        check("async_rst_multi_hit", 64'(multi_hit), 64'd0);
        check("async_rst_out_data",  64'(out_data),  64'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 34'h0, 32'h0, 10'h000, 1'b0, 10'h3FF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst%0d_out_valid", i), 64'(out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ah_pkt_dispatch_34_10.md
Name: ah_pkt_dispatch_34_10

Overview:
- Registered packet-steering stage placed directly downstream of the 34-bit / 10-client range decoder.
- Accepts ingress packets (address plus payload) on a valid/ready handshake and takes the decoder's one-hot select and dec_err for the presented address.
- Forwards each packet, one cycle later, to exactly one of 10 client egress channels.
- Drops undecodable packets, reports each with a single-cycle error pulse and keeps a saturating error count.

Parameters:
- ADDR_W, 34, width of ingress_pkt_field / packet address.
- DATA_W, 32, packet payload width.
- N_CLIENTS, 10, number of client egress channels (width of decoded select).
- ERR_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ingress packet valid.
- in_ready  out  1  ingress packet ready.
- ingress_pkt_field  in  ADDR_W  packet address; also routed to the decoder.
- in_data  in  DATA_W  packet payload.
- decoded_binary  in  N_CLIENTS  one-hot client select from the decoder (combinational from ingress_pkt_field).
- dec_err  in  1  decoder miss flag.
- out_valid  out  N_CLIENTS  per-client valid; at most one bit set.
- out_ready  in  N_CLIENTS  per-client ready.
- out_addr  out  ADDR_W  shared egress address bus.
- out_data  out  DATA_W  shared egress payload bus.
- err_valid  out  1  one-cycle pulse per dropped packet.
- err_addr  out  ADDR_W  address of the last dropped packet.
- err_cnt  out  ERR_CNT_W  saturating dropped-packet count.
- multi_hit  out  1  sticky flag: a multi-hot select was seen.

Behaviour:
- Reset (async, rst_n=0): hold_v=0, out_valid=0, out_addr=0, out_data=0, err_valid=0, err_addr=0, err_cnt=0, multi_hit=0, sel register=0.
  - in_ready is 1 out of reset.
  - A reset asserted mid-transfer discards any held packet; nothing is replayed.
- Single holding register (hold_v, hold_addr, hold_data, hold_sel[N_CLIENTS]).
- State machine, two states:
  - EMPTY (hold_v=0).
  - FULL (hold_v=1).
- Signal definitions:
  - out_valid = {N_CLIENTS{hold_v}} & hold_sel.
  - out_addr / out_data = hold_addr / hold_data.
  - leave = hold_v & |(hold_sel & out_ready).
  - in_ready = ~hold_v | leave. This is a combinational path out_ready→in_ready, and it is intentional.
  - accept = in_valid & in_ready.
- Routing, evaluated on accept:
  - dec_err=1, or decoded_binary==0: packet dropped.
    - err_valid=1 next cycle only.
    - err_addr <= ingress_pkt_field.
    - err_cnt increments, saturating at all-ones with no wrap.
    - hold register not loaded; the next state is EMPTY if leave, otherwise unchanged.
  - Exactly one bit set: load hold, hold_sel=decoded_binary, next state FULL.
  - More than one bit set (overlapping ranges): lowest-index set bit wins, hold loaded with that single bit, multi_hit set.
    - multi_hit clears only on reset.
- State transitions:
  - EMPTY→FULL on accept of a good packet.
  - FULL→EMPTY on leave with no good accept.
  - FULL→FULL on leave with a simultaneous good accept: back-to-back, full throughput, one packet per cycle.
  - FULL holds while the selected out_ready=0. in_ready=0, and out_valid, out_addr and out_data stay stable until taken.
- Latency: accept at edge N → out_valid visible after edge N, consumable at edge N+1.
- An error packet arriving while FULL and stalled waits (in_ready=0); error packets never bypass the handshake.
- out_ready bits of non-selected clients are ignored.
- in_data and ingress_pkt_field are sampled only on accept; values with in_valid=0 have no effect.

Decomposition:
- Shared package ah_dispatch_pkg:
  - ADDR_W / DATA_W / N_CLIENTS defaults.
  - Packet struct typedef {addr, data}.
  - Client-select typedef logic [N_CLIENTS-1:0].
- One natural sub-module: ah_lowest_onehot, a combinational priority-select that returns the lowest set bit plus a multi flag.
- Counter and hold register stay inline.

Test Plan:
- Reset release: rst_n low then high → in_ready=1, all out_valid=0, err_cnt=0, multi_hit=0.
- Single packet: addr 0x0000_1000, data 0xDEADBEEF, decoded_binary=10'b0000000001, out_ready=all 1 → out_valid[0]=1 exactly one cycle later with matching addr/data; in_ready stays 1.
- Stall and back-to-back: 3 packets to client 2, out_ready[2]=0 for 4 cycles → out_valid[2] held with the first packet unchanged, in_ready=0. Release → packets drain in order, one per cycle, no loss or duplication.
- Error: dec_err=1, addr 0x3_FFFF_FFFF → no out_valid, err_valid pulses once, err_addr=0x3_FFFF_FFFF, err_cnt=1. With ERR_CNT_W=4, 17 errors → err_cnt=15.
- Multi-hot: decoded_binary=10'b0000001010 → out_valid[1] only, multi_hit=1 and still 1 after 10 more clean packets.
- Reset mid-stall: FULL with out_ready=0, pulse rst_n low → out_valid=0 immediately (asynchronously), in_ready=1, held packet never appears.
